// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Provides: state_t and alu_op_t enums, opcode/funct codes, datapath mux
// encodings, exception cause codes, EXC_VECTOR, the ctrl_t control word
// and small funct-decode helpers.
// CTRL_EXC_EN adds the EXC state to state_t.
package ctrl_pkg;

    localparam int unsigned STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_LUI,
        S_JUMP,
        S_JAL,
        S_JR,
        S_BR_ADDR,
        S_BR_CMP,
        S_HALT
`ifdef CTRL_EXC_EN
        ,
        S_EXC
`endif
    } state_t;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_INC  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_COMP = 3'd7
    } alu_op_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Functs (IR[5:0]) for opcode 0
    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_LUI    = 2'd2;
    localparam logic [1:0] M2R_PC     = 2'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_A      = 3'd3;
    localparam logic [2:0] PCSRC_EXC    = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_OVF     = 2'd2;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       mdr_write;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] mem_to_reg;
        logic [2:0] pc_source;
        alu_op_t    alu_op;
        logic       halted;
        logic       epc_write;
        logic [1:0] cause;
    } ctrl_t;

    function automatic logic is_rtype_alu(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
    endfunction

    function automatic alu_op_t funct_alu_op(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_wait_counter.sv
// wait_counter: counts cycles spent in a multi-cycle state.
// Ports: clock, reset (async, active-high), enable (count permitted),
//        clear (synchronous zero, wins over counting), done (count == MAX_COUNT).
// Width is $clog2(MAX_COUNT+1), at least 1; the count saturates at MAX_COUNT.
module wait_counter #(
    parameter int unsigned MAX_COUNT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic done
);
    localparam int unsigned CNT_W = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;

    logic [CNT_W-1:0] count_q;

    assign done = (count_q == CNT_W'(MAX_COUNT));

    // Saturating counter, cleared whenever the owning FSM changes state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (enable) begin
            if (clear) begin
                count_q <= '0;
            end else if (!done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: Moore-style FSM sequencing fetch/decode/execute/
// memory/write-back for the shared single-memory MIPS datapath.
// Inputs : clock, reset (async, active-high), opcode, funct (from IR),
//          zero, overflow (same-cycle ALU flags).
// Outputs: datapath enables and mux selects, alu_op, state_out, halted,
//          epc_write, cause.
// MEM_WAIT: extra cycles per memory access (0..15).
// Define CTRL_EXC_EN to enable the EXC state (overflow / illegal traps).
module multicycle_ctrl_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       a_write,
    output logic       b_write,
    output logic       alu_out_write,
    output logic       mdr_write,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_src_b,
    output logic [1:0] mem_to_reg,
    output logic [2:0] pc_source,
    output logic [2:0] alu_op,
    output logic [5:0] state_out,
    output logic       halted,
    output logic       epc_write,
    output logic [1:0] cause
);
    import ctrl_pkg::*;

    state_t state_q, state_d;
    logic   run_q;
    logic   wait_done;
    logic   wait_clear;
    logic   quiet;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

`ifdef CTRL_EXC_EN
    logic [1:0] cause_q, cause_d;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    // Shared wait counter for FETCH / MEM_READ / MEM_WRITE
    wait_counter #(
        .MAX_COUNT(MEM_WAIT)
    ) u_wait (
        .clock (clock),
        .reset (reset),
        .enable(run_q),
        .clear (wait_clear),
        .done  (wait_done)
    );

    assign wait_clear = (state_d != state_q);

    // State register; run_q holds the FSM idle until the first edge after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
`ifdef CTRL_EXC_EN
            cause_q <= CAUSE_NONE;
`endif
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q <= state_d;
`ifdef CTRL_EXC_EN
                cause_q <= cause_d;
`endif
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
`ifdef CTRL_EXC_EN
        cause_d = cause_q;
`endif
        case (state_q)
            S_FETCH: begin
                ctrl.iord      = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.mdr_write = 1'b1;
                if (wait_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.a_write   = 1'b1;
                ctrl.b_write   = 1'b1;
                state_d        = S_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        if (is_rtype_alu(funct)) begin
                            state_d = S_R_EXEC;
                        end else if (funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (funct == FN_BREAK) begin
                            state_d = S_HALT;
                        end else if (funct != FN_NOP) begin
`ifdef CTRL_EXC_EN
                            state_d = S_EXC;
                            cause_d = CAUSE_ILLEGAL;
`else
                            state_d = S_FETCH;
`endif
                        end
                    end
                    OP_ADDI:      state_d = S_I_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_LUI:       state_d = S_LUI;
                    OP_BEQ, OP_BNE: state_d = S_BR_ADDR;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
`ifdef CTRL_EXC_EN
                        state_d = S_EXC;
                        cause_d = CAUSE_ILLEGAL;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_R_EXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = funct_alu_op(funct);
                ctrl.alu_out_write = 1'b1;
                state_d            = S_R_WB;
`ifdef CTRL_EXC_EN
                // Only signed add/sub trap; and/xor cannot overflow
                if (overflow && ((funct == FN_ADD) || (funct == FN_SUB))) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end
`endif
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                state_d         = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                state_d            = S_I_WB;
`ifdef CTRL_EXC_EN
                if (overflow) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVF;
                end
`endif
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                state_d         = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                state_d            = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctrl.iord      = 1'b1;
                ctrl.mdr_write = 1'b1;
                if (wait_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.iord   = 1'b1;
                ctrl.mem_wr = 1'b1;
                if (wait_done) state_d = S_FETCH;
            end
            S_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_LUI;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from DECODE, so it is the link value
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                state_d         = S_FETCH;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_A;
                state_d        = S_FETCH;
            end
            S_BR_ADDR: begin
                ctrl.alu_src_a     = 1'b0;
                ctrl.alu_src_b     = SRCB_IMM_SH;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                state_d            = S_BR_CMP;
            end
            S_BR_CMP: begin
                // opcode[0] distinguishes bne (taken on !zero) from beq
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = zero ^ opcode[0];
                state_d        = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
`ifdef CTRL_EXC_EN
            S_EXC: begin
                ctrl.epc_write = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_EXC;
                ctrl.cause     = cause_q;
                state_d        = S_FETCH;
                cause_d        = CAUSE_NONE;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Everything reads zero while reset is held and until the FSM starts
    assign quiet    = reset || !run_q;
    assign ctrl_out = quiet ? ctrl_t'('0) : ctrl;

    assign pc_write      = ctrl_out.pc_write;
    assign iord          = ctrl_out.iord;
    assign mem_wr        = ctrl_out.mem_wr;
    assign ir_write      = ctrl_out.ir_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign reg_write     = ctrl_out.reg_write;
    assign a_write       = ctrl_out.a_write;
    assign b_write       = ctrl_out.b_write;
    assign alu_out_write = ctrl_out.alu_out_write;
    assign mdr_write     = ctrl_out.mdr_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign pc_source     = ctrl_out.pc_source;
    assign alu_op        = ctrl_out.alu_op;
    assign halted        = ctrl_out.halted;
    assign epc_write     = ctrl_out.epc_write;
    assign cause         = ctrl_out.cause;
    assign state_out     = quiet ? 6'd0 : 6'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Testbench for multicycle_ctrl_unit: dut0 (MEM_WAIT=2) and dut1 (MEM_WAIT=0).
// An instruction-level model expands each instruction into the per-cycle
// output records it must produce; a negedge process compares them.
module tb_multicycle_ctrl_unit;

    typedef struct packed {
        logic [5:0] st;
        logic       pc_write;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       mdr_write;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] mem_to_reg;
        logic [2:0] pc_source;
        logic [2:0] alu_op;
        logic       halted;
        logic       epc_write;
        logic [1:0] cause;
    } obs_t;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_R_EXEC = 2, ST_R_WB = 3;
    localparam int ST_I_EXEC = 4, ST_I_WB = 5, ST_MEM_ADDR = 6, ST_MEM_READ = 7;
    localparam int ST_MEM_WB = 8, ST_MEM_WRITE = 9, ST_LUI = 10, ST_JUMP = 11;
    localparam int ST_JAL = 12, ST_JR = 13, ST_BR_ADDR = 14, ST_BR_CMP = 15;
    localparam int ST_HALT = 16, ST_EXC = 17;
    localparam int HALT_HOLD = 50;

`ifdef CTRL_EXC_EN
    localparam bit EXC_EN    = 1'b1;
    localparam int ILL_LEN_A = 5;
`else
    localparam bit EXC_EN    = 1'b0;
    localparam int ILL_LEN_A = 4;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] opc [2];
    logic [5:0] fnc [2];
    logic       zr  [2];
    logic       ovf [2];
    obs_t       act0, act1;
    obs_t       q0[$];
    obs_t       q1[$];
    obs_t       e0, e1;
    int         checks;
    int         failures;
    string      cur_name;

    multicycle_ctrl_unit #(.MEM_WAIT(2)) dut0 (
        .clock(clk), .reset(reset), .opcode(opc[0]), .funct(fnc[0]),
        .zero(zr[0]), .overflow(ovf[0]),
        .pc_write(act0.pc_write), .iord(act0.iord), .mem_wr(act0.mem_wr),
        .ir_write(act0.ir_write), .alu_src_a(act0.alu_src_a),
        .reg_write(act0.reg_write), .a_write(act0.a_write), .b_write(act0.b_write),
        .alu_out_write(act0.alu_out_write), .mdr_write(act0.mdr_write),
        .reg_dst(act0.reg_dst), .alu_src_b(act0.alu_src_b),
        .mem_to_reg(act0.mem_to_reg), .pc_source(act0.pc_source),
        .alu_op(act0.alu_op), .state_out(act0.st), .halted(act0.halted),
        .epc_write(act0.epc_write), .cause(act0.cause)
    );

    multicycle_ctrl_unit #(.MEM_WAIT(0)) dut1 (
        .clock(clk), .reset(reset), .opcode(opc[1]), .funct(fnc[1]),
        .zero(zr[1]), .overflow(ovf[1]),
        .pc_write(act1.pc_write), .iord(act1.iord), .mem_wr(act1.mem_wr),
        .ir_write(act1.ir_write), .alu_src_a(act1.alu_src_a),
        .reg_write(act1.reg_write), .a_write(act1.a_write), .b_write(act1.b_write),
        .alu_out_write(act1.alu_out_write), .mdr_write(act1.mdr_write),
        .reg_dst(act1.reg_dst), .alu_src_b(act1.alu_src_b),
        .mem_to_reg(act1.mem_to_reg), .pc_source(act1.pc_source),
        .alu_op(act1.alu_op), .state_out(act1.st), .halted(act1.halted),
        .epc_write(act1.epc_write), .cause(act1.cause)
    );

    always #5 clk = ~clk;

    function automatic obs_t rec(input int st);
        obs_t r;
        r    = '0;
        r.st = 6'(st);
        return r;
    endfunction

    function automatic obs_t exc_rec(input logic [1:0] c);
        obs_t r;
        r           = rec(ST_EXC);
        r.epc_write = 1'b1;
        r.pc_write  = 1'b1;
        r.pc_source = 3'd4;
        r.cause     = c;
        return r;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Instruction-level model: what each cycle of one instruction must show
    task automatic model_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic ov, output int n);
        int   w;
        obs_t r;
        obs_t seq[$];
        bit   r_alu;
        w = (d == 0) ? 3 : 1;
        for (int i = 0; i < w; i++) begin
            r = rec(ST_FETCH); r.ir_write = 1'b1; r.mdr_write = 1'b1;
            seq.push_back(r);
        end
        r = rec(ST_DECODE); r.pc_write = 1'b1; r.alu_src_b = 2'd1; r.alu_op = 3'd1;
        r.a_write = 1'b1; r.b_write = 1'b1;
        seq.push_back(r);
        r_alu = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h26);
        if (r_alu) begin
            r = rec(ST_R_EXEC); r.alu_src_a = 1'b1; r.alu_out_write = 1'b1;
            case (fn)
                6'h20:   r.alu_op = 3'd1;
                6'h22:   r.alu_op = 3'd2;
                6'h24:   r.alu_op = 3'd3;
                default: r.alu_op = 3'd6;
            endcase
            seq.push_back(r);
            if (EXC_EN && ov && (fn == 6'h20 || fn == 6'h22)) seq.push_back(exc_rec(2'd2));
            else begin
                r = rec(ST_R_WB); r.reg_write = 1'b1; r.reg_dst = 2'd1; seq.push_back(r);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            r = rec(ST_JR); r.pc_write = 1'b1; r.pc_source = 3'd3; seq.push_back(r);
        end else if (op == 6'h00 && fn == 6'h0D) begin
            for (int i = 0; i < HALT_HOLD; i++) begin
                r = rec(ST_HALT); r.halted = 1'b1; seq.push_back(r);
            end
        end else if (op == 6'h00 && fn == 6'h00) begin
            // nop: straight back to fetch
        end else if (op == 6'h08) begin
            r = rec(ST_I_EXEC); r.alu_src_a = 1'b1; r.alu_src_b = 2'd2; r.alu_op = 3'd1;
            r.alu_out_write = 1'b1; seq.push_back(r);
            if (EXC_EN && ov) seq.push_back(exc_rec(2'd2));
            else begin
                r = rec(ST_I_WB); r.reg_write = 1'b1; seq.push_back(r);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            r = rec(ST_MEM_ADDR); r.alu_src_a = 1'b1; r.alu_src_b = 2'd2; r.alu_op = 3'd1;
            r.alu_out_write = 1'b1; seq.push_back(r);
            for (int i = 0; i < w; i++) begin
                if (op == 6'h23) begin
                    r = rec(ST_MEM_READ); r.iord = 1'b1; r.mdr_write = 1'b1;
                end else begin
                    r = rec(ST_MEM_WRITE); r.iord = 1'b1; r.mem_wr = 1'b1;
                end
                seq.push_back(r);
            end
            if (op == 6'h23) begin
                r = rec(ST_MEM_WB); r.reg_write = 1'b1; r.mem_to_reg = 2'd1; seq.push_back(r);
            end
        end else if (op == 6'h0F) begin
            r = rec(ST_LUI); r.reg_write = 1'b1; r.mem_to_reg = 2'd2; seq.push_back(r);
        end else if (op == 6'h04 || op == 6'h05) begin
            r = rec(ST_BR_ADDR); r.alu_src_b = 2'd3; r.alu_op = 3'd1; r.alu_out_write = 1'b1;
            seq.push_back(r);
            r = rec(ST_BR_CMP); r.alu_src_a = 1'b1; r.alu_op = 3'd2; r.pc_source = 3'd1;
            r.pc_write = (op == 6'h05) ? !z : z;
            seq.push_back(r);
        end else if (op == 6'h02) begin
            r = rec(ST_JUMP); r.pc_write = 1'b1; r.pc_source = 3'd2; seq.push_back(r);
        end else if (op == 6'h03) begin
            r = rec(ST_JAL); r.reg_write = 1'b1; r.reg_dst = 2'd2; r.mem_to_reg = 2'd3;
            r.pc_write = 1'b1; r.pc_source = 3'd2; seq.push_back(r);
        end else begin
            if (EXC_EN) seq.push_back(exc_rec(2'd1));
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (d == 0) q0.push_back(seq[i]);
            else        q1.push_back(seq[i]);
        end
        n = seq.size();
    endtask

    task automatic wait_drain(input int d);
        for (int i = 0; i < 400 && qsize(d) != 0; i++) @(posedge clk);
        if (qsize(d) != 0) begin
            checks++;
            failures++;
            $display("FAIL %s drain timeout dut%0d left=%0d", cur_name, d, qsize(d));
            if (d == 0) q0.delete(); else q1.delete();
        end
        #1;
    endtask

    // Called #1 after the edge that starts the instruction's first FETCH cycle
    task automatic run(input int d, input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov, input int exp_len);
        int n;
        cur_name = nm;
        opc[d] = op; fnc[d] = fn; zr[d] = z; ovf[d] = ov;
        model_instr(d, op, fn, z, ov, n);
        chk({nm, "_len"}, 64'(n), 64'(exp_len));
        wait_drain(d);
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0) begin
            e0 = q0.pop_front();
            checks++;
            if (act0 !== e0) begin
                failures++;
                $display("FAIL %s dut0 cycle got=%h exp=%h", cur_name, act0, e0);
            end
        end
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            checks++;
            if (act1 !== e1) begin
                failures++;
                $display("FAIL %s dut1 cycle got=%h exp=%h", cur_name, act1, e1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cur_name = "reset";
        clk = 1'b0; reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            opc[i] = 6'h00; fnc[i] = 6'h00; zr[i] = 1'b0; ovf[i] = 1'b0;
        end
        #3;
        chk("reset_out_dut0", 64'(act0), 64'd0);
        chk("reset_out_dut1", 64'(act1), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // MEM_WAIT=2: W=3
        run(0, "add",        6'h00, 6'h20, 1'b0, 1'b0, 6);
        run(0, "sub",        6'h00, 6'h22, 1'b0, 1'b0, 6);
        run(0, "and",        6'h00, 6'h24, 1'b0, 1'b0, 6);
        run(0, "xor",        6'h00, 6'h26, 1'b0, 1'b0, 6);
        run(0, "addi",       6'h08, 6'h00, 1'b0, 1'b0, 6);
        run(0, "addi_ovf",   6'h08, 6'h00, 1'b0, 1'b1, 6);
        run(0, "add_ovf",    6'h00, 6'h20, 1'b0, 1'b1, 6);
        run(0, "xor_ovf",    6'h00, 6'h26, 1'b0, 1'b1, 6);
        run(0, "lw",         6'h23, 6'h00, 1'b0, 1'b0, 9);
        run(0, "sw",         6'h2B, 6'h00, 1'b0, 1'b0, 8);
        run(0, "lui",        6'h0F, 6'h00, 1'b0, 1'b0, 5);
        run(0, "j",          6'h02, 6'h00, 1'b0, 1'b0, 5);
        run(0, "jal",        6'h03, 6'h00, 1'b0, 1'b0, 5);
        run(0, "jr",         6'h00, 6'h08, 1'b0, 1'b0, 5);
        run(0, "beq_z1",     6'h04, 6'h00, 1'b1, 1'b0, 6);
        run(0, "beq_z0",     6'h04, 6'h00, 1'b0, 1'b0, 6);
        run(0, "bne_z0",     6'h05, 6'h00, 1'b0, 1'b0, 6);
        run(0, "bne_z1",     6'h05, 6'h00, 1'b1, 1'b0, 6);
        run(0, "nop",        6'h00, 6'h00, 1'b0, 1'b0, 4);
        run(0, "ill_op3f",   6'h3F, 6'h00, 1'b0, 1'b0, ILL_LEN_A);
        run(0, "ill_funct",  6'h00, 6'h01, 1'b0, 1'b0, ILL_LEN_A);
        run(0, "break",      6'h00, 6'h0D, 1'b0, 1'b0, 3 + 1 + HALT_HOLD);

        // Still halted; reset mid-cycle must clear outputs without a clock edge
        cur_name = "halt_reset";
        chk("halt_state", 64'(act0.st), 64'd16);
        chk("halt_flag",  64'(act0.halted), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_state_out", 64'(act0.st), 64'd0);
        chk("rst_halted",    64'(act0.halted), 64'd0);
        chk("rst_all_dut0",  64'(act0), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // MEM_WAIT=0: W=1
        run(1, "lw_w0",  6'h23, 6'h00, 1'b0, 1'b0, 5);
        run(1, "add_w0", 6'h00, 6'h20, 1'b0, 1'b0, 4);
        run(1, "sw_w0",  6'h2B, 6'h00, 1'b0, 1'b0, 4);
        run(1, "bne_w0", 6'h05, 6'h00, 1'b0, 1'b0, 4);
        run(1, "jal_w0", 6'h03, 6'h00, 1'b0, 1'b0, 3);

        // Abort a load in MEM_READ with reset, then confirm a clean restart
        cur_name = "abort";
        opc[1] = 6'h23; fnc[1] = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_mem_read", {58'd0, act1.st}, 64'd7);
        chk("abort_iord",        64'(act1.iord), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_all_zero", 64'(act1), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        run(1, "lw_after_abort", 6'h23, 6'h00, 1'b0, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_unit.md
# multicycle_ctrl_unit

Parametrised multicycle MIPS control unit that sequences fetch, decode, execute, memory and write-back for the shared single-memory datapath. Memory latency is a parameter, driven by one wait counter instead of per-latency states. Over the previous unit it adds `addi`, `bne`, `jal`, `jr` and a sticky halt. It drives every datapath enable and mux select, plus the ALU operation, from a single Moore-style FSM. `zero` and `overflow` are the only same-cycle inputs.

## Interface
- MEM_WAIT, 2, extra memory cycles per access; 0..15 are legal values.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0 (combinational)
- overflow  in  1  ALU signed overflow (combinational)
- pc_write, iord, mem_wr, ir_write, alu_src_a, reg_write, a_write, b_write, alu_out_write, mdr_write  out  1 each  datapath enables/selects
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=imm<<16, 3=PC
- pc_source  out  3  0=ALU, 1=ALUOut, 2=jump target, 3=A, 4=EXC_VECTOR
- alu_op  out  3  LOAD/ADD/SUB/AND/INC/NEG/XOR/COMP = 0..7
- state_out  out  6  current state index
- halted  out  1  break executed
- epc_write  out  1  EPC load; drives 0 unless CTRL_EXC_EN
- cause  out  2  0=none, 1=illegal instruction, 2=overflow

## Operation
- The FSM has the following states: FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, LUI, JUMP, JAL, JR, BR_ADDR, BR_CMP, HALT, EXC.
- FETCH: iord=0, ir_write=1, mdr_write=1. The state holds for MEM_WAIT+1 cycles, then goes to DECODE.
- DECODE: pc_write=1, pc_source=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, a_write=b_write=1. Next-state dispatch:
  - opcode 0x00, funct 20/22/24/26 → R_EXEC
  - opcode 0x00, funct 08 → JR
  - opcode 0x00, funct 0D → HALT
  - opcode 0x00, funct 00 → FETCH
  - opcode 08 → I_EXEC
  - opcode 23/2B → MEM_ADDR
  - opcode 0F → LUI
  - opcode 04/05 → BR_ADDR
  - opcode 02 → JUMP
  - opcode 03 → JAL
  - anything else → FETCH, or EXC with cause=1 under the macro.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_out_write=1. alu_op from funct: 20→ADD, 22→SUB, 24→AND, 26→XOR. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, ADD, alu_out_write=1. Next state is I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD, alu_out_write=1. Next state is MEM_READ (opcode 23) or MEM_WRITE (opcode 2B).
- MEM_READ: iord=1, mdr_write=1. Holds MEM_WAIT+1 cycles, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state is FETCH.
- MEM_WRITE: iord=1, mem_wr=1. Holds MEM_WAIT+1 cycles, then FETCH.
- LUI: reg_write=1, reg_dst=0, mem_to_reg=2. Next state is FETCH.
- JUMP: pc_write=1, pc_source=2. Next state is FETCH.
- JAL: reg_write=1, reg_dst=2, mem_to_reg=3, pc_write=1, pc_source=2. PC already holds PC+4 at this point. Next state is FETCH.
- JR: pc_write=1, pc_source=3. Next state is FETCH.
- BR_ADDR: alu_src_a=0, alu_src_b=3, ADD, alu_out_write=1. Next state is BR_CMP.
- BR_CMP: alu_src_a=1, alu_src_b=0, SUB. pc_source=1 and pc_write = zero XOR opcode[0]. Next state is FETCH.
- HALT: halted=1. The FSM stays here until reset.
- Signals not listed for a state are driven to 0; alu_op defaults to LOAD. No output is ever X.

## Timing
- State register is asynchronous-reset to FETCH; the wait counter is asynchronous-reset to 0.
- While reset is high, every enable, select, alu_op, state_out, halted, epc_write and cause is forced to 0.
- The first FETCH cycle follows the first rising edge after reset deasserts.
- Instruction latency, with W = MEM_WAIT+1:
  - R-type, addi: W+3
  - lw: W+W+3
  - sw: W+W+2
  - lui, j, jal, jr: W+2
  - beq/bne: W+3
- The wait counter clears on every state change. A multi-cycle state exits on the cycle the counter equals MEM_WAIT.
- zero and overflow are sampled only in the cycle they are used (BR_CMP, and R_EXEC/I_EXEC respectively).
- Reset asserted mid-access aborts immediately; no partial write-back occurs.

## Configuration
- CTRL_EXC_EN defined:
  - Overflow in R_EXEC with funct 20/22, or in I_EXEC, goes to EXC instead of write-back.
  - Illegal opcode/funct goes to EXC.
  - EXC drives epc_write=1, pc_write=1, pc_source=4 and holds cause for that one cycle, then returns to FETCH.
  - The destination register is never written on an exception.
- CTRL_EXC_EN undefined: the EXC state is absent, overflow is ignored, illegal instructions act as nop, and epc_write=cause=0.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum and the alu_op enum
  - opcode/funct localparams
  - pc_source, mem_to_reg, reg_dst and alu_src_b encodings
  - EXC_VECTOR = 32'h0000_0080
- One sub-module, `wait_counter`: parametrised width $clog2(MEM_WAIT+1) (min 1), with clear, done and an asynchronous reset.

## Test plan
- MEM_WAIT=2, add (op 00, funct 20): FETCH×3, DECODE, R_EXEC (alu_op=1), R_WB (reg_write=1, reg_dst=1) → 6 cycles total.
- MEM_WAIT=0, lw (op 23): state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, with iord=1 in MEM_READ.
- bne (op 05): zero=0 in BR_CMP → pc_write=1, pc_source=1; zero=1 → pc_write=0. beq inverts this.
- jal (op 03) → reg_dst=2, mem_to_reg=3, pc_source=2 in a single cycle. jr (00/08) → pc_source=3.
- break (00/0D) → halted=1 held for 50 cycles; reset → state_out=0 and halted=0 asynchronously.
- CTRL_EXC_EN: addi with overflow=1 → EXC, epc_write=1, cause=2, no reg_write. Opcode 3F → cause=1.
